// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide scheduler: op codes, FSM states, op decode.
// No logic of its own.
package md_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;
   localparam int CNT_W_DEF       = 4;

   // Signedness does not change the busy time; only the class matters.
   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Loadable down-counter for remaining mul/div busy cycles; load wins over decrement.
// Output registered; zero_next flags the final busy cycle (cnt==1).
module md_cycle_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_dec,
   input  logic [CNT_W-1:0] i_load_val,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_zero_next
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_cnt       = r_cnt;
   assign o_zero_next = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/md_stall_sched.sv
// Schedules the multi-cycle mul/div unit and freezes F/D + bubbles E for HI/LO users.
// Result pulse N+1 cycles after start; stall/flush are combinational with no added latency.
module md_stall_sched
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             e_start,
   input  logic [1:0]       e_op,
   input  logic             d_uses_md,
   output logic             busy,
   output logic             md_done,
   output logic             md_is_div,
   output logic             stall_FD,
   output logic             flush_DE,
   output logic [CNT_W-1:0] cnt,
   output logic             err
);

   if (MULT_CYCLES < 1 || MULT_CYCLES >= (1 << CNT_W) ||
       DIV_CYCLES  < 1 || DIV_CYCLES  >= (1 << CNT_W)) begin : g_param_chk
      $error("md_stall_sched: MULT_CYCLES/DIV_CYCLES must lie in 1..2**CNT_W-1");
   end

   localparam logic [CNT_W-1:0] LP_MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] LP_DIV_LOAD  = CNT_W'(DIV_CYCLES);

   logic             r_state;
   logic             r_md_done;
   logic             r_md_is_div;
   logic             r_err;

   logic             w_is_div;
   logic             w_load;
   logic             w_dec;
   logic             w_zero_next;
   logic [CNT_W-1:0] w_load_val;
   logic [CNT_W-1:0] w_cnt;

   assign w_is_div   = op_is_div(e_op);
   assign w_load     = e_start & (r_state == ST_IDLE);
   assign w_dec      = (r_state == ST_BUSY);
   assign w_load_val = w_is_div ? LP_DIV_LOAD : LP_MULT_LOAD;

   md_cycle_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_load),
      .i_dec       (w_dec),
      .i_load_val  (w_load_val),
      .o_cnt       (w_cnt),
      .o_zero_next (w_zero_next)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_md_done   <= 1'b0;
         r_md_is_div <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_md_done <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (e_start) begin
               r_state     <= ST_BUSY;
               r_md_is_div <= w_is_div;
            end
         end else begin
            // A start here is dropped; the counter keeps running the current op.
            if (e_start) begin
               r_err <= 1'b1;
            end
            if (w_zero_next) begin
               r_state   <= ST_IDLE;
               r_md_done <= 1'b1;
            end
         end
      end
   end

   assign busy      = e_start | (r_state == ST_BUSY);
   assign stall_FD  = d_uses_md & busy;
   assign flush_DE  = d_uses_md & busy;
   assign md_done   = r_md_done;
   assign md_is_div = r_md_is_div;
   assign cnt       = w_cnt;
   assign err       = r_err;

endmodule

// File: tb/tb_md_stall_sched.sv
// Directed bench for md_stall_sched: reset, mult/div latency, stall window,
// back-to-back starts, async reset abort and the sticky illegal-start flag.
module tb_md_stall_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       e_start;
   logic [1:0] e_op;
   logic       d_uses_md;
   logic       busy;
   logic       md_done;
   logic       md_is_div;
   logic       stall_FD;
   logic       flush_DE;
   logic [3:0] cnt;
   logic       err;

   int n_vec = 0;
   int n_err = 0;
   int seen_done;

   always #5 clk = ~clk;

   md_stall_sched #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10),
      .CNT_W       (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .e_start   (e_start),
      .e_op      (e_op),
      .d_uses_md (d_uses_md),
      .busy      (busy),
      .md_done   (md_done),
      .md_is_div (md_is_div),
      .stall_FD  (stall_FD),
      .flush_DE  (flush_DE),
      .cnt       (cnt),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge; inputs are driven here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with a start request present
      reset = 1'b0; e_start = 1'b1; e_op = 2'b10; d_uses_md = 1'b0;
      cyc(); cyc(); #1;
      chk("rst_cnt", cnt, 0);
      chk("rst_done", md_done, 0);
      chk("rst_err", err, 0);
      chk("rst_isdiv", md_is_div, 0);
      chk("rst_busy_comb", busy, 1);
      chk("rst_stall", stall_FD, 0);
      chk("rst_flush", flush_DE, 0);
      e_start = 1'b0; #1;
      chk("rst_idle", busy, 0);
      cyc(); reset = 1'b1;
      cyc(); #1;
      chk("post_rst_busy", busy, 0);

      // mult: busy cycles 0..5, cnt 5..1 in cycles 1..5, md_done in cycle 6
      cyc(); e_start = 1'b1; e_op = 2'b00; #1;
      chk("mul_c0_busy", busy, 1);
      chk("mul_c0_cnt", cnt, 0);
      for (int c = 1; c <= 5; c++) begin
         cyc(); e_start = 1'b0; #1;
         chk($sformatf("mul_c%0d_busy", c), busy, 1);
         chk($sformatf("mul_c%0d_cnt", c), cnt, 6 - c);
         chk($sformatf("mul_c%0d_done", c), md_done, 0);
      end
      cyc(); #1;
      chk("mul_c6_done", md_done, 1);
      chk("mul_c6_busy", busy, 0);
      chk("mul_c6_cnt", cnt, 0);
      chk("mul_c6_isdiv", md_is_div, 0);
      cyc(); #1;
      chk("mul_c7_done", md_done, 0);

      // div with a dependent mflo waiting in D
      cyc(); e_start = 1'b1; e_op = 2'b10; d_uses_md = 1'b1; #1;
      chk("div_c0_stall", stall_FD, 1);
      chk("div_c0_flush", flush_DE, 1);
      for (int c = 1; c <= 10; c++) begin
         cyc(); e_start = 1'b0; #1;
         chk($sformatf("div_c%0d_stall", c), stall_FD, 1);
         chk($sformatf("div_c%0d_flush", c), flush_DE, 1);
         chk($sformatf("div_c%0d_cnt", c), cnt, 11 - c);
         chk($sformatf("div_c%0d_done", c), md_done, 0);
      end
      chk("div_isdiv", md_is_div, 1);
      cyc(); #1;
      chk("div_c11_stall", stall_FD, 0);
      chk("div_c11_flush", flush_DE, 0);
      chk("div_c11_done", md_done, 1);
      cyc(); d_uses_md = 1'b0;

      // Back-to-back: mult, then multu started in the md_done cycle
      cyc(); e_start = 1'b1; e_op = 2'b00; #1;
      for (int c = 1; c <= 5; c++) begin
         cyc(); e_start = 1'b0; #1;
         chk($sformatf("b2b_a%0d_cnt", c), cnt, 6 - c);
      end
      chk("b2b_isdiv_cleared", md_is_div, 0);
      cyc(); e_start = 1'b1; e_op = 2'b01; #1;
      chk("b2b_c6_done", md_done, 1);
      chk("b2b_c6_busy", busy, 1);
      for (int c = 7; c <= 11; c++) begin
         cyc(); e_start = 1'b0; #1;
         chk($sformatf("b2b_c%0d_busy", c), busy, 1);
         chk($sformatf("b2b_c%0d_cnt", c), cnt, 12 - c);
         chk($sformatf("b2b_c%0d_done", c), md_done, 0);
      end
      cyc(); #1;
      chk("b2b_c12_done", md_done, 1);
      chk("b2b_c12_isdiv", md_is_div, 0);

      // Async reset in the middle of a divu
      cyc(); e_start = 1'b1; e_op = 2'b11; #1;
      for (int c = 1; c <= 7; c++) begin
         cyc(); e_start = 1'b0;
      end
      #1;
      chk("arst_pre_cnt", cnt, 4);
      #1; reset = 1'b0; #1;
      chk("arst_cnt_now", cnt, 0);
      chk("arst_idle_now", busy, 0);
      #1; reset = 1'b1;
      seen_done = 0;
      for (int c = 0; c < 15; c++) begin
         cyc(); #1;
         if (md_done) seen_done++;
      end
      chk("arst_no_done", seen_done, 0);
      chk("arst_still_idle", busy, 0);

      // Illegal start while BUSY at cnt==3
      cyc(); e_start = 1'b1; e_op = 2'b00; #1;
      cyc(); e_start = 1'b0;
      cyc(); #1;
      chk("ill_pre_cnt", cnt, 4);
      cyc(); e_start = 1'b1; e_op = 2'b10; #1;
      chk("ill_c3_cnt", cnt, 3);
      chk("ill_c3_err", err, 0);
      cyc(); e_start = 1'b0; #1;
      chk("ill_c4_cnt", cnt, 2);
      chk("ill_c4_err", err, 1);
      chk("ill_c4_isdiv", md_is_div, 0);
      cyc(); #1;
      chk("ill_c5_cnt", cnt, 1);
      cyc(); #1;
      chk("ill_c6_done", md_done, 1);
      cyc(); cyc(); #1;
      chk("ill_err_sticky", err, 1);
      reset = 1'b0; #1;
      chk("ill_err_cleared", err, 0);
      cyc(); reset = 1'b1;
      cyc(); #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
